// File: rtl/cpu_pkg.sv
// Shared fetch-path types: FSM state encoding, FIFO entry layout and a saturating counter helper.
package cpu_pkg;

  localparam int          INSTR_W         = 32;
  localparam int          PC_W            = 32;
  localparam logic [31:0] PC_STEP_DEFAULT = 32'd4;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_entry_t;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] delta);
    logic [32:0] sum;
    sum = {1'b0, value} + {1'b0, delta};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with push/pop/clear; the head is read straight
// from storage so it holds while not popped.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fetch_entry_t  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
  always_comb begin
    do_pop_s  = pop && (count_r != '0);
    do_push_s = push && ((count_r != FULL_CNT) || do_pop_s);
  end

  // Pointer and occupancy tracking; clear wins over push and pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      if (do_push_s && !do_pop_s)      count_r <= count_r + CW'(1);
      else if (!do_push_s && do_pop_s) count_r <= count_r - CW'(1);
    end
  end

  // Entry storage, reset to zero so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (do_push_s && !clear) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == FULL_CNT);
  assign empty = (count_r == '0);

  fetch_fifo_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .count (count_r)
  );

endmodule

// File: rtl/fetch_fifo_chk.sv
// Protocol checker for fetch_fifo: flags a push into a full FIFO that no pop makes room for.
module fetch_fifo_chk #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          clk,
  input logic          reset,
  input logic          clear,
  input logic          push,
  input logic          pop,
  input logic [CW-1:0] count
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push && !clear && !pop && (count == FULL_CNT)));

  count_in_range: assert property (@(posedge clk) disable iff (!reset)
    count <= FULL_CNT);

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generation, credit-limited reads, FIFO buffering, redirect and halt.
// Optional FETCH_STATS_EN adds saturating fetched/flushed counters.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter  int          DEPTH    = 4,
  parameter  logic [31:0] RESET_PC = 32'h0000_0000,
  parameter  logic [31:0] PC_STEP  = PC_STEP_DEFAULT,
  localparam int          AW       = $clog2(DEPTH),
  localparam int          CW       = AW + 1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        halted
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_flushed
`endif
);

  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  fetch_state_t  state_r;
  logic [31:0]   fetch_pc_r;
  logic [31:0]   inflight_pc_r;
  logic          inflight_r;
  logic          issue_s;
  logic          push_s;
  logic          pop_s;
  logic [CW:0]   credit_used_s;
  logic [CW-1:0] count_s;
  logic          full_s;
  logic          empty_s;
  fetch_entry_t  head_s;
  fetch_entry_t  push_entry_s;

  // Words queued plus the one in flight must stay below DEPTH, so a return always finds a slot.
  always_comb begin
    credit_used_s      = {1'b0, count_s} + {{CW{1'b0}}, inflight_r};
    issue_s            = (state_r == RUN) && !redirect && !full_s && (credit_used_s < DEPTH_W);
    push_s             = inflight_r && !redirect;
    pop_s              = !empty_s && instr_ready;
    push_entry_s.instr = mem_rdata;
    push_entry_s.pc    = inflight_pc_r;
  end

  // PC generation and in-flight tracking; a redirect kills the return by suppressing its push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_r    <= RESET_PC;
      inflight_r    <= 1'b0;
      inflight_pc_r <= '0;
    end else begin
      inflight_r <= issue_s;
      if (issue_s) inflight_pc_r <= fetch_pc_r;
      if (redirect)     fetch_pc_r <= redirect_pc;
      else if (issue_s) fetch_pc_r <= fetch_pc_r + PC_STEP;
    end
  end

  // Fetch FSM; redirect overrides every state except the single post-reset BOOT cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= BOOT;
    end else if (redirect && (state_r != BOOT)) begin
      state_r <= halt ? HALTED : RUN;
    end else begin
      case (state_r)
        BOOT:    state_r <= RUN;
        RUN:     if (halt) state_r <= DRAIN;
        DRAIN:   if (!inflight_r) state_r <= HALTED;
        HALTED:  if (!halt) state_r <= RUN;
        default: state_r <= BOOT;
      endcase
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (redirect),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .head      (head_s),
    .count     (count_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  assign mem_read    = issue_s;
  assign mem_addr    = fetch_pc_r;
  assign instr       = head_s.instr;
  assign instr_pc    = head_s.pc;
  assign instr_valid = !empty_s;
  assign halted      = (state_r == HALTED) && halt;

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched_r;
  logic [31:0] stat_flushed_r;
  logic [31:0] flush_amt_s;

  // Entries still queued after an honoured pop, plus the killed in-flight word.
  always_comb begin
    flush_amt_s = 32'(count_s) - {31'd0, pop_s} + {31'd0, inflight_r};
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_fetched_r <= '0;
      stat_flushed_r <= '0;
    end else begin
      if (push_s)   stat_fetched_r <= sat_inc(stat_fetched_r, 32'd1);
      if (redirect) stat_flushed_r <= sat_inc(stat_flushed_r, flush_amt_s);
    end
  end

  assign stat_fetched = stat_fetched_r;
  assign stat_flushed = stat_flushed_r;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Table-driven bench for fetch_queue: streaming, backpressure, redirect, halt, async reset and PC wrap.
`timescale 1ns/1ps
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_addr, mem_rdata, redirect_pc, instr, instr_pc;
  logic        mem_read, redirect, halt, instr_valid, instr_ready, halted;
  logic [31:0] w_mem_addr, w_mem_rdata, w_redirect_pc, w_instr, w_instr_pc;
  logic        w_mem_read, w_redirect, w_halt, w_instr_valid, w_instr_ready, w_halted;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched, stat_flushed, w_stat_fetched, w_stat_flushed;
`endif

  always #5 clk = ~clk;

  fetch_queue u_dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_read(mem_read), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt), .instr(instr),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready), .halted(halted)
`ifdef FETCH_STATS_EN
    , .stat_fetched(stat_fetched), .stat_flushed(stat_flushed)
`endif
  );

  fetch_queue #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
    .clk(clk), .reset(reset), .mem_addr(w_mem_addr), .mem_read(w_mem_read), .mem_rdata(w_mem_rdata),
    .redirect(w_redirect), .redirect_pc(w_redirect_pc), .halt(w_halt), .instr(w_instr),
    .instr_pc(w_instr_pc), .instr_valid(w_instr_valid), .instr_ready(w_instr_ready), .halted(w_halted)
`ifdef FETCH_STATS_EN
    , .stat_fetched(w_stat_fetched), .stat_flushed(w_stat_flushed)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'h1000_0000 + {2'b00, addr[31:2]};
  endfunction

  always @(posedge clk) begin
    if (mem_read)   mem_rdata   <= mem_word(mem_addr);
    if (w_mem_read) w_mem_rdata <= mem_word(w_mem_addr);
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        ready;
    logic        hlt;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_read;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_halted;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic ready, input logic hlt, input logic redir,
                              input logic [31:0] rpc, input logic exp_read,
                              input logic [31:0] exp_addr, input logic exp_valid,
                              input logic [31:0] exp_pc, input logic exp_halted);
    vec_t v;
    v.ready = ready; v.hlt = hlt; v.redir = redir; v.rpc = rpc;
    v.exp_read = exp_read; v.exp_addr = exp_addr; v.exp_valid = exp_valid;
    v.exp_pc = exp_pc; v.exp_halted = exp_halted;
    return v;
  endfunction

  initial begin
    reset = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; halt = 1'b0; instr_ready = 1'b0;
    w_redirect = 1'b0; w_redirect_pc = 32'd0; w_halt = 1'b0; w_instr_ready = 1'b1;

    // One record per cycle after reset release: ready, halt, redirect, redirect_pc,
    // expected mem_read, mem_addr, instr_valid, instr_pc (when valid), halted.
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h000, 1'b0, 32'h000, 1'b0)); // BOOT
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h000, 1'b0, 32'h000, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h004, 1'b0, 32'h000, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h008, 1'b1, 32'h000, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h00C, 1'b1, 32'h000, 1'b0));
    for (int k = 5; k <= 10; k++)
      vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h010, 1'b1, 32'h000, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h010, 1'b1, 32'h000, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h010, 1'b1, 32'h004, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h014, 1'b1, 32'h008, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h018, 1'b1, 32'h00C, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h01C, 1'b1, 32'h010, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h020, 1'b1, 32'h014, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h024, 1'b1, 32'h018, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h028, 1'b1, 32'h01C, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 32'h02C, 1'b1, 32'h01C, 1'b0)); // redirect
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h000, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h000, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h100, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h10C, 1'b1, 32'h104, 1'b0)); // halt
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h110, 1'b1, 32'h108, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h110, 1'b1, 32'h10C, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h110, 1'b0, 32'h000, 1'b1));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h110, 1'b0, 32'h000, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h110, 1'b0, 32'h000, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h110, 1'b0, 32'h000, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h114, 1'b0, 32'h000, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h118, 1'b1, 32'h110, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h11C, 1'b1, 32'h114, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h120, 1'b1, 32'h114, 1'b0));

    // Reset state.
    @(negedge clk); @(negedge clk);
    check("rst mem_read", {31'd0, mem_read}, 32'd0);
    check("rst mem_addr", mem_addr, 32'h0);
    check("rst instr_valid", {31'd0, instr_valid}, 32'd0);
    check("rst instr", instr, 32'h0);
    check("rst instr_pc", instr_pc, 32'h0);
    check("rst halted", {31'd0, halted}, 32'd0);
    check("rst wrap mem_addr", w_mem_addr, 32'hFFFF_FFF8);

    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < vecs.size(); k++) begin
      instr_ready = vecs[k].ready;
      halt        = vecs[k].hlt;
      redirect    = vecs[k].redir;
      redirect_pc = vecs[k].rpc;
      #1;
      check($sformatf("v%0d mem_read", k), {31'd0, mem_read}, {31'd0, vecs[k].exp_read});
      check($sformatf("v%0d mem_addr", k), mem_addr, vecs[k].exp_addr);
      check($sformatf("v%0d instr_valid", k), {31'd0, instr_valid}, {31'd0, vecs[k].exp_valid});
      if (vecs[k].exp_valid) begin
        check($sformatf("v%0d instr_pc", k), instr_pc, vecs[k].exp_pc);
        check($sformatf("v%0d instr", k), instr, mem_word(vecs[k].exp_pc));
      end
      check($sformatf("v%0d halted", k), {31'd0, halted}, {31'd0, vecs[k].exp_halted});
      @(negedge clk);
    end

    // Three queued plus one in flight; reset asserted mid-cycle must clear outputs at once.
    redirect = 1'b0; halt = 1'b0; instr_ready = 1'b0;
    #1;
    check("full3 mem_read", {31'd0, mem_read}, 32'd0);
    check("full3 instr_pc", instr_pc, 32'h114);
    #1 reset = 1'b0;
    #1;
    check("async instr_valid", {31'd0, instr_valid}, 32'd0);
    check("async mem_read", {31'd0, mem_read}, 32'd0);
    check("async mem_addr", mem_addr, 32'h0);
    check("async instr", instr, 32'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1; instr_ready = 1'b1;
    #1;
    check("reboot mem_read", {31'd0, mem_read}, 32'd0);
    check("reboot wrap mem_read", {31'd0, w_mem_read}, 32'd0);
    @(negedge clk); #1;
    check("reboot addr0", mem_addr, 32'h0);
    check("reboot read0", {31'd0, mem_read}, 32'd1);
    check("wrap addr0", w_mem_addr, 32'hFFFF_FFF8);
    @(negedge clk); #1;
    check("wrap addr1", w_mem_addr, 32'hFFFF_FFFC);
    @(negedge clk); #1;
    check("wrap addr2", w_mem_addr, 32'h0000_0000);
    check("wrap read2", {31'd0, w_mem_read}, 32'd1);
    check("wrap pc0", w_instr_pc, 32'hFFFF_FFF8);
    check("wrap instr0", w_instr, 32'h4FFF_FFFE);
    check("reboot valid pc0", instr_pc, 32'h0);
    check("reboot valid", {31'd0, instr_valid}, 32'd1);
    @(negedge clk); #1;
    check("wrap pc1", w_instr_pc, 32'hFFFF_FFFC);
    check("wrap addr3", w_mem_addr, 32'h0000_0004);

    // Redirect with a same-cycle pop: head consumed, in-flight word (pc 8) killed.
    redirect = 1'b1; redirect_pc = 32'h200;
    #1;
    check("rpop mem_read", {31'd0, mem_read}, 32'd0);
    check("rpop head pc", instr_pc, 32'h4);
    @(negedge clk);
    redirect = 1'b0;
    #1;
    check("rpop valid after", {31'd0, instr_valid}, 32'd0);
    check("rpop new addr", mem_addr, 32'h200);
    @(negedge clk); #1;
    check("rpop valid gap", {31'd0, instr_valid}, 32'd0);
    @(negedge clk); #1;
    check("rpop first pc", instr_pc, 32'h200);
    check("rpop first instr", instr, 32'h1000_0080);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
